booth_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 6-bit signed Booth multiplier instance among NREQ requesters.
- Accepts one operand pair at a time and holds the operands stable on the multiplier inputs.
- Pulses the multiplier start and waits the multiplier's worst-case latency, since the multiplier has no done flag.
- Captures the 12-bit product and returns it with the requester ID over a valid/ready response port.

---
 rtl/booth_mul_arbiter.sv | 166 ++++++++++++++++
 tb/tb_booth_mul_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin sequencer sharing one 6x6 signed Booth multiplier
// among NREQ requesters. One operand pair in flight at a time; response is
// returned with the owning requester ID. Latency accept->rsp_valid = MUL_WAIT+1.
// Backpressure: holds in RESP while i_rsp_ready is low; requesters wait (req_ready=0).
// Ports:
//   i_clk, i_n_rst            clock, synchronous active-low reset (shared with multiplier)
//   i_req_valid/m/q           per-requester request and 6-bit signed operands
//   o_req_ready               one-hot accept strobe (IDLE only)
//   o_mul_start/m/q           multiplier start strobe and registered operands
//   i_mul_result              12-bit product from the multiplier
//   o_rsp_valid/data/id       response port, i_rsp_ready from the sink
//   o_busy                    high in every state except IDLE
module booth_mul_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MUL_WAIT = 26
) (
  input  logic              i_clk,
  input  logic              i_n_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [6*NREQ-1:0] i_req_m,
  input  logic [6*NREQ-1:0] i_req_q,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_mul_start,
  output logic [5:0]        o_mul_m,
  output logic [5:0]        o_mul_q,
  input  logic [11:0]       i_mul_result,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [11:0]       o_rsp_data,
  output logic [IDW-1:0]    o_rsp_id,
  output logic              o_busy
);

  localparam int CW = $clog2(MUL_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [5:0]       r_mul_m;
  logic [5:0]       r_mul_q;
  logic [11:0]      r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [NREQ-1:0]  w_gnt_oh;
  logic [5:0]       w_sel_m;
  logic [5:0]       w_sel_q;
  logic             w_accept;

  // Round-robin search starting just after the last grant, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    logic [31:0] v_idx;
    w_found = 1'b0;
    w_gnt   = '0;
    v_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = 32'(r_ptr) + 32'(k);
      if (v_idx >= 32'(NREQ)) v_idx = v_idx - 32'(NREQ);
      if (!w_found && i_req_valid[v_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_idx[IDW-1:0];
      end
    end
  end

  // Operand mux and one-hot decode of the winner.
  always_comb begin
    w_gnt_oh = '0;
    w_sel_m  = '0;
    w_sel_q  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt == IDW'(i)) begin
        w_gnt_oh[i] = 1'b1;
        w_sel_m     = i_req_m[6*i +: 6];
        w_sel_q     = i_req_q[6*i +: 6];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    o_mul_start = 1'b0;
    o_rsp_valid = 1'b0;
    o_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_found) begin
          o_req_ready = w_gnt_oh;
          w_state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        o_mul_start = 1'b1;
        w_state_nxt = S_WAIT;
      end
      // Counter loaded with MUL_WAIT-2 and exits on zero: MUL_WAIT-1 cycles,
      // so CAPTURE samples the product MUL_WAIT edges after start was seen.
      S_WAIT: begin
        if (r_cnt == '0) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_rst) begin
      r_ptr      <= IDW'(NREQ - 1);
      r_cnt      <= '0;
      r_mul_m    <= '0;
      r_mul_q    <= '0;
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else begin
      if (w_accept) begin
        r_mul_m  <= w_sel_m;
        r_mul_q  <= w_sel_q;
        r_rsp_id <= w_gnt;
        r_ptr    <= w_gnt;
      end
      if (r_state == S_LAUNCH) begin
        r_cnt <= CW'(MUL_WAIT - 2);
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (r_state == S_CAPTURE) begin
        r_rsp_data <= i_mul_result;
      end
    end
  end

  assign o_mul_m    = r_mul_m;
  assign o_mul_q    = r_mul_q;
  assign o_rsp_data = r_rsp_data;
  assign o_rsp_id   = r_rsp_id;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: directed bench for booth_mul_arbiter with a
// behavioural multiplier that publishes its product MUL_WAIT edges after
// sampling start and shows a poison value while computing.
module tb_booth_mul_arbiter;
  localparam int NREQ     = 4;
  localparam int IDW      = 2;
  localparam int MUL_WAIT = 26;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [6*NREQ-1:0] req_m = '0;
  logic [6*NREQ-1:0] req_q = '0;
  logic [NREQ-1:0]   req_ready;
  logic              mul_start;
  logic [5:0]        mul_m;
  logic [5:0]        mul_q;
  logic [11:0]       mul_result;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [11:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  booth_mul_arbiter #(.NREQ(NREQ), .IDW(IDW), .MUL_WAIT(MUL_WAIT)) dut (
    .i_clk        (clk),
    .i_n_rst      (n_rst),
    .i_req_valid  (req_valid),
    .i_req_m      (req_m),
    .i_req_q      (req_q),
    .o_req_ready  (req_ready),
    .o_mul_start  (mul_start),
    .o_mul_m      (mul_m),
    .o_mul_q      (mul_q),
    .i_mul_result (mul_result),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_data   (rsp_data),
    .o_rsp_id     (rsp_id),
    .o_busy       (busy)
  );

  // Multiplier model: result register becomes valid on the MUL_WAIT-th edge
  // counting the start-sampling edge as the first.
  logic signed [11:0] pm, pq;
  logic [11:0]        mprod;
  int                 mcnt;
  assign pm = {{6{mul_m[5]}}, mul_m};
  assign pq = {{6{mul_q[5]}}, mul_q};

  always @(posedge clk) begin
    if (!n_rst) begin
      mcnt       <= 0;
      mul_result <= 12'hAAA;
      mprod      <= 12'h000;
    end else if (mul_start) begin
      mcnt       <= MUL_WAIT - 1;
      mprod      <= 12'(pm * pq);
      mul_result <= 12'hAAA;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_result <= mprod;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    chk({tag, "_mul_start"}, 32'(mul_start), 32'(0));
    chk({tag, "_mul_m"},     32'(mul_m),     32'(0));
    chk({tag, "_mul_q"},     32'(mul_q),     32'(0));
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'(0));
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'(0));
    chk({tag, "_busy"},      32'(busy),      32'(0));
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    n_rst = 1'b1;
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 in LAUNCH.
  task automatic issue(input int id, input logic [5:0] m, input logic [5:0] q);
    req_m[6*id +: 6] = m;
    req_q[6*id +: 6] = q;
    req_valid[id]    = 1'b1;
    #1;
    chk("accept_ready", 32'(req_ready), 32'(1) << id);
    chk("accept_idle",  32'(busy), 32'(0));
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    chk("launch_m",    32'(mul_m), 32'(m));
    chk("launch_q",    32'(mul_q), 32'(q));
    chk("launch_busy", 32'(busy),  32'(1));
  endtask

  task automatic finish_op(input int id, input logic [11:0] exp, input int stall, input int pend);
    int n = 0;
    int starts = 0;
    int rrbad = 0;
    int hold_bad = 0;
    if (pend >= 0) req_valid[pend] = 1'b1;
    while (!rsp_valid && n < 100) begin
      if (mul_start) starts++;
      if (req_ready != '0) rrbad++;
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency",      32'(n),      32'(MUL_WAIT + 1));
    chk("start_pulses", 32'(starts), 32'(1));
    chk("busy_ready",   32'(rrbad),  32'(0));
    chk("rsp_data",     32'(rsp_data), 32'(exp));
    chk("rsp_id",       32'(rsp_id),   32'(id));
    if (stall > 0) begin
      repeat (stall) begin
        @(posedge clk);
        #1;
        if (!rsp_valid || rsp_data !== exp || rsp_id !== IDW'(id) || req_ready != '0)
          hold_bad++;
      end
      chk("stall_hold", 32'(hold_bad), 32'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("idle_after_rsp", 32'(busy),      32'(0));
    chk("rsp_drop",       32'(rsp_valid), 32'(0));
    if (pend >= 0) chk("pending_ready", 32'(req_ready), 32'(1) << pend);
  endtask

  int          rr_order [5] = '{0, 1, 2, 3, 0};
  logic [11:0] rr_prod  [4] = '{12'h006, 12'hFEC, 12'h3C1, 12'h03F};

  initial begin
    int nrsp, ngnt, cyc, bad, stray;

    do_reset();

    issue(0, 6'h05, 6'h03); finish_op(0, 12'h00F, 0, -1);
    issue(2, 6'h07, 6'h3F); finish_op(2, 12'hFF9, 0, -1);
    issue(1, 6'h20, 6'h20); finish_op(1, 12'h400, 0, -1);
    issue(1, 6'h20, 6'h1F); finish_op(1, 12'hC20, 0, -1);

    // Stalled response with requester 0 pending the whole time.
    issue(3, 6'h03, 6'h3E); finish_op(3, 12'hFFA, 10, 0);
    issue(0, 6'h3F, 6'h3F); finish_op(0, 12'h001, 0, -1);

    // All requesters asserting continuously.
    do_reset();
    req_m = {6'h39, 6'h1F, 6'h3C, 6'h02};
    req_q = {6'h37, 6'h1F, 6'h05, 6'h03};
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    nrsp = 0; ngnt = 0; cyc = 0; bad = 0;
    while (nrsp < 5 && cyc < 400) begin
      if (req_ready != '0) begin
        if (busy) bad++;
        if (ngnt < 5) chk("rr_grant", 32'(req_ready), 32'(1) << rr_order[ngnt]);
        else bad++;
        ngnt++;
      end
      if (rsp_valid) begin
        chk("rr_id",   32'(rsp_id),   32'(rr_order[nrsp]));
        chk("rr_data", 32'(rsp_data), 32'(rr_prod[rr_order[nrsp]]));
        nrsp++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("rr_rsps",   32'(nrsp), 32'(5));
    chk("rr_grants", 32'(ngnt), 32'(5));
    chk("rr_misc",   32'(bad),  32'(0));

    // Reset pulse in the middle of WAIT aborts the operation.
    issue(1, 6'h0A, 6'h0B);
    repeat (11) begin
      @(posedge clk);
      #1;
    end
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset("abort");
    n_rst = 1'b1;
    stray = 0;
    repeat (40) begin
      if (rsp_valid || busy || req_ready != '0) stray++;
      @(posedge clk);
      #1;
    end
    chk("abort_quiet", 32'(stray), 32'(0));
    issue(2, 6'h06, 6'h3B); finish_op(2, 12'hFE2, 0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
